// File: rtl/btb_predictor_if.sv
// ---------------------------------------------------------------------------
// btb_predictor_if
//
// Purpose:
//    Bundles the IF-stage lookup signals and the EX-stage training signals of
//    the branch target buffer into one interface. The pipeline side uses the
//    master modport and the predictor uses the slave modport.
//
// Signal summary:
//    predict_pc        fetch PC presented by the IF stage (32 bits)
//    predict_hit       a valid entry's tag matches predict_pc
//    predict_taken     the matching entry predicts taken
//    predict_next_pc   stored target when hit and taken, else predict_pc+4
//    update_en         EX resolved a conditional branch this cycle
//    update_pc         PC of the resolved branch
//    update_taken      actual branch outcome
//    update_target     actual taken target
//    update_mispredict pipeline mispredicted this branch (qualified by update_en)
//    mispredict_count  saturating count of mispredicted branches
// ---------------------------------------------------------------------------
interface btb_predictor_if;

   logic [31:0] predict_pc;
   logic        predict_hit;
   logic        predict_taken;
   logic [31:0] predict_next_pc;

   logic        update_en;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic        update_mispredict;

   logic [31:0] mispredict_count;

   // Pipeline side: drives the fetch PC and the resolution results.
   modport master (
      output predict_pc,
      input  predict_hit,
      input  predict_taken,
      input  predict_next_pc,
      output update_en,
      output update_pc,
      output update_taken,
      output update_target,
      output update_mispredict,
      input  mispredict_count
   );

   // Predictor side: answers lookups and absorbs training.
   modport slave (
      input  predict_pc,
      output predict_hit,
      output predict_taken,
      output predict_next_pc,
      input  update_en,
      input  update_pc,
      input  update_taken,
      input  update_target,
      input  update_mispredict,
      output mispredict_count
   );

endinterface

// File: rtl/btb_predictor.sv
// ---------------------------------------------------------------------------
// btb_predictor
//
// Purpose:
//    Direct-mapped branch target buffer with a saturating direction counter
//    per entry. Lookup is combinational from the fetch PC (zero latency);
//    training from the EX stage is applied on the rising clk edge. A 32-bit
//    saturating counter tracks mispredicted branches for performance runs.
//
// Ports:
//    clk    clock
//    reset  synchronous, active-high; flushes the table and the counter
//    bus    btb_predictor_if.slave (lookup, update and counter signals)
//
// Parameters:
//    ENTRIES   number of table entries, power of 2, >= 4
//    TAG_BITS  tag width taken from the PC bits just above the index
//    CNT_BITS  direction counter width, >= 1
//
// Optional build macro:
//    BTB_GSHARE_EN  when defined, the table index is the PC index XORed with
//                   a global branch history register (gshare indexing). Tags
//                   stay pure PC bits and the port list is unchanged.
// ---------------------------------------------------------------------------
module btb_predictor #(
   parameter int ENTRIES  = 64,
   parameter int TAG_BITS = 8,
   parameter int CNT_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   btb_predictor_if.slave   bus
);

   localparam int IDX_W  = $clog2(ENTRIES);
   localparam int TAG_LO = IDX_W + 2;
   localparam int TAG_HI = IDX_W + 1 + TAG_BITS;

   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
   localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);

   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

   logic [31:0]         mispredict_q;

   logic [IDX_W-1:0]    pred_idx;
   logic [TAG_BITS-1:0] pred_tag;
   logic [IDX_W-1:0]    upd_idx;
   logic [TAG_BITS-1:0] upd_tag;
   logic                upd_hit;

   // The two low PC bits and everything above the tag never reach the table.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.predict_pc[31:TAG_HI+1], bus.predict_pc[1:0],
                             bus.update_pc[31:TAG_HI+1],  bus.update_pc[1:0]};

`ifdef BTB_GSHARE_EN
   logic [IDX_W-1:0] ghr_q;

   // Global history: shift in every resolved outcome. The update index below
   // uses the value before this shift, since both read ghr_q on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         ghr_q <= '0;
      end else if (bus.update_en) begin
         ghr_q <= {ghr_q[IDX_W-2:0], bus.update_taken};
      end
   end

   // Gshare indexing: PC index folded with history for both lookup and update.
   assign pred_idx = bus.predict_pc[IDX_W+1:2] ^ ghr_q;
   assign upd_idx  = bus.update_pc[IDX_W+1:2]  ^ ghr_q;
`else
   // Plain direct-mapped indexing straight from the word-aligned PC.
   assign pred_idx = bus.predict_pc[IDX_W+1:2];
   assign upd_idx  = bus.update_pc[IDX_W+1:2];
`endif

   assign pred_tag = bus.predict_pc[TAG_HI:TAG_LO];
   assign upd_tag  = bus.update_pc[TAG_HI:TAG_LO];

   // Lookup reads the registered table directly, so a same-cycle update to the
   // same entry is not visible until the following cycle (read-old).
   assign bus.predict_hit     = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
   assign bus.predict_taken   = bus.predict_hit && cnt_q[pred_idx][CNT_BITS-1];
   assign bus.predict_next_pc = bus.predict_taken ? target_q[pred_idx]
                                                  : bus.predict_pc + 32'd4;

   // Training side tag compare against the entry the resolved branch maps to.
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   // Valid bits and direction counters. A hit trains the counter with
   // saturation at both ends; a taken miss (re)allocates the entry as weakly
   // taken; a not-taken miss leaves the table alone. Reset wins over any
   // concurrent update so the flush is never partially undone.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= '0;
         end
      end else if (bus.update_en) begin
         if (upd_hit) begin
            if (bus.update_taken) begin
               if (cnt_q[upd_idx] != CNT_MAX) begin
                  cnt_q[upd_idx] <= cnt_q[upd_idx] + CNT_BITS'(1);
               end
            end else begin
               if (cnt_q[upd_idx] != '0) begin
                  cnt_q[upd_idx] <= cnt_q[upd_idx] - CNT_BITS'(1);
               end
            end
         end else if (bus.update_taken) begin
            valid_q[upd_idx] <= 1'b1;
            cnt_q[upd_idx]   <= CNT_WEAK;
         end
      end
   end

   // Tag and target payload carry no reset: they are meaningless while the
   // valid bit is clear. Any taken update writes both, which covers a hit
   // (tag rewritten with the same value) and an allocation alike.
   always_ff @(posedge clk) begin
      if (!reset && bus.update_en && bus.update_taken) begin
         tag_q[upd_idx]    <= upd_tag;
         target_q[upd_idx] <= bus.update_target;
      end
   end

   // Misprediction counter: the mispredict flag only counts when qualified by
   // update_en, and the counter sticks at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         mispredict_q <= '0;
      end else if (bus.update_en && bus.update_mispredict && (mispredict_q != '1)) begin
         mispredict_q <= mispredict_q + 32'd1;
      end
   end

   assign bus.mispredict_count = mispredict_q;

endmodule
